// File: rtl/cpu_result_tx.sv
// Serializes each captured {result, flags} word as a framed, even-parity bit stream on tx_out,
// with a one-deep holding buffer so the CPU never stalls on back-to-back results.
module cpu_result_tx #(
  parameter int DATA_W       = 8,
  parameter int FLAG_W       = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result,
  input  logic [FLAG_W-1:0] flags,
  input  logic              clear_overrun,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  localparam int NB = DATA_W + FLAG_W;
  localparam int IW = $clog2(NB);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PEN  = TW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [IW-1:0]   idx_q;
  logic [NB-1:0]   shreg_q;
  logic            par_q;
  logic [NB-1:0]   buf_q;
  logic            buf_full_q;
  logic            tx_q, busy_q, done_q, overrun_q;
  logic [7:0]      cnt_q;

  logic            tick, leave_stop, at_gap, launch, buf_load, ovr_set;
  logic [NB-1:0]   in_word, launch_word;

  // A frame may only begin from IDLE or on the final edge of a stop bit.
  assign in_word     = {result, flags};
  assign tick        = (timer_q == T_LAST);
  assign leave_stop  = (state_q == STOP) && tick;
  assign at_gap      = (state_q == IDLE) || leave_stop;
  assign launch      = at_gap && (result_valid || buf_full_q);
  assign launch_word = buf_full_q ? buf_q : in_word;
  assign buf_load    = result_valid && (at_gap ? buf_full_q : !buf_full_q);
  assign ovr_set     = result_valid && !at_gap && buf_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      timer_q    <= (state_q == IDLE || tick) ? '0 : timer_q + 1'b1;
      done_q     <= (state_q == PARITY && tick && CLKS_PER_BIT == 1) ||
                    (state_q == STOP && !tick && timer_q == T_PEN);
      buf_full_q <= at_gap ? (buf_full_q & result_valid) : (buf_full_q | result_valid);
      overrun_q  <= ovr_set | (overrun_q & ~clear_overrun);
      if (leave_stop) cnt_q <= cnt_q + 8'd1;

      if (launch) begin
        state_q <= START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          START: if (tick) begin
            state_q <= DATA;
            idx_q   <= IW'(NB - 1);
            tx_q    <= shreg_q[NB-1];
          end
          DATA: if (tick) begin
            if (idx_q == '0) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              idx_q <= idx_q - 1'b1;
              tx_q  <= shreg_q[NB-2];
            end
          end
          PARITY: if (tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Payload registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (launch) begin
      shreg_q <= launch_word;
      par_q   <= ^launch_word;
    end else if (state_q == DATA && tick && idx_q != '0) begin
      shreg_q <= shreg_q << 1;
    end
    if (buf_load) buf_q <= in_word;
  end

  assign tx_out    = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign overrun   = overrun_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_result_tx.sv
// Bench for cpu_result_tx: two instances (1 and 4 clocks per bit) on shared stimulus,
// compared every cycle against a frame-timeline reference model.
module tb_cpu_result_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rv, clr;
  logic [7:0] res;
  logic [3:0] flg;
  logic [1:0] tx, busy, done, ovr;
  logic [7:0] cnt0, cnt1;

  cpu_result_tx #(.DATA_W(8), .FLAG_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .result_valid(rv), .result(res), .flags(flg),
    .clear_overrun(clr), .tx_out(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]),
    .overrun(ovr[0]), .frame_cnt(cnt0));

  cpu_result_tx #(.DATA_W(8), .FLAG_W(4), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .result_valid(rv), .result(res), .flags(flg),
    .clear_overrun(clr), .tx_out(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]),
    .overrun(ovr[1]), .frame_cnt(cnt1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one active frame (bit pattern + cycle position) and a pending word.
  int         cpb[2] = '{1, 4};
  bit         m_act[2];
  int         m_pos[2];
  logic [14:0] m_fr[2];
  bit         m_bv[2];
  logic [11:0] m_bd[2];
  bit         m_ovr[2];
  int         m_cnt[2];

  function automatic logic [14:0] frame_of(input logic [11:0] d);
    return {1'b0, d, ^d, 1'b1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_bv[i] = 0; m_ovr[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_start(input int i, input logic [11:0] d);
    m_act[i] = 1; m_pos[i] = 0; m_fr[i] = frame_of(d);
  endtask

  task automatic model_step(input bit v, input logic [11:0] d, input bit c);
    for (int i = 0; i < 2; i++) begin
      bit ending, set;
      set = 0;
      ending = m_act[i] && (m_pos[i] == 15 * cpb[i] - 1);
      if (ending) m_cnt[i] = (m_cnt[i] + 1) % 256;
      if (!m_act[i] || ending) begin
        if (m_bv[i]) begin
          model_start(i, m_bd[i]);
          if (v) m_bd[i] = d; else m_bv[i] = 0;
        end else if (v) model_start(i, d);
        else m_act[i] = 0;
      end else begin
        m_pos[i]++;
        if (v) begin
          if (!m_bv[i]) begin m_bv[i] = 1; m_bd[i] = d; end
          else set = 1;
        end
      end
      m_ovr[i] = set ? 1'b1 : (c ? 1'b0 : m_ovr[i]);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic etx, edn;
      etx = m_act[i] ? m_fr[i][14 - m_pos[i] / cpb[i]] : 1'b1;
      edn = m_act[i] && (m_pos[i] == 15 * cpb[i] - 1);
      check($sformatf("tx%0d", i), tx[i], etx);
      check($sformatf("busy%0d", i), busy[i], m_act[i]);
      check($sformatf("done%0d", i), done[i], edn);
      check($sformatf("ovr%0d", i), ovr[i], m_ovr[i]);
      check($sformatf("cnt%0d", i), (i == 0) ? cnt0 : cnt1, m_cnt[i]);
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input logic [3:0] f, input bit c);
    rv  = v;
    res = v ? d : 8'($urandom);
    flg = v ? f : 4'($urandom);
    clr = c;
    @(posedge clk);
    if (rst_n) model_step(v, {d, f}, c); else model_reset();
    @(negedge clk);
    compare_all();
    rv = 0; clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 8'h00, 4'h0, 0);
  endtask

  task automatic pulse(input logic [7:0] d, input logic [3:0] f);
    cycle(1, d, f, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_act[0] || m_act[1] || m_bv[0] || m_bv[1]) && k < 400) begin
      idle(1);
      k++;
    end
    check("wait_idle_bound", k < 400, 1);
  endtask

  task automatic frame15(input logic [7:0] d, input logic [3:0] f, input logic [14:0] exp_seq,
                         input string tag);
    logic [14:0] seq;
    int bc, dpos;
    logic [7:0] c0;
    c0 = cnt0;
    pulse(d, f);
    seq = {14'b0, tx[0]}; bc = busy[0]; dpos = done[0] ? 1 : 0;
    for (int j = 2; j <= 15; j++) begin
      idle(1);
      seq = {seq[13:0], tx[0]};
      bc += busy[0];
      if (done[0]) dpos = j;
    end
    check({tag, "_seq"}, seq, exp_seq);
    check({tag, "_busy_cycles"}, bc, 15);
    check({tag, "_done_pos"}, dpos, 15);
    idle(1);
    check({tag, "_busy_after"}, busy[0], 0);
    check({tag, "_cnt"}, cnt0, 8'(c0 + 8'd1));
  endtask

  initial begin
    logic [7:0]  c0;
    logic [59:0] s4, e4;
    logic [14:0] f4;
    logic        par4;
    int          run, bc4;
    bit          broken;

    rst_n = 1'b0; rv = 0; clr = 0; res = 0; flg = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 2'b11);
    check("rst_busy", busy, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_ovr", ovr, 2'b00);
    check("rst_cnt", {cnt1, cnt0}, 16'h0000);
    rst_n = 1'b1;
    idle(3);

    frame15(8'h1A, 4'b0000, 15'b000011010000011, "f1a");
    wait_idle();
    frame15(8'h00, 4'b0010, 15'b000000000001011, "fz");
    wait_idle();

    // Back-to-back frames: second pulse three cycles after the first.
    c0 = cnt0; run = 0; broken = 0;
    for (int j = 0; j < 45; j++) begin
      if (j == 0) pulse(8'h05, 4'h0);
      else if (j == 3) pulse(8'h06, 4'h0);
      else idle(1);
      if (busy[0] && !broken) run++;
      else if (run > 0) broken = 1;
    end
    check("b2b_busy_run", run, 30);
    check("b2b_cnt", cnt0, 8'(c0 + 8'd2));
    check("b2b_ovr", ovr[0], 0);
    wait_idle();

    // Overrun: third word dropped, then cleared.
    c0 = cnt0;
    pulse(8'h01, 4'h0); pulse(8'h02, 4'h0); pulse(8'h03, 4'h0);
    wait_idle();
    check("ovr_set", ovr[0], 1);
    check("ovr_cnt", cnt0, 8'(c0 + 8'd2));
    cycle(0, 8'h00, 4'h0, 1);
    check("ovr_clear", ovr[0], 0);
    // Clear and a fresh overrun in the same cycle: set wins.
    pulse(8'h11, 4'h1); pulse(8'h22, 4'h2); cycle(1, 8'h33, 4'h3, 1);
    check("ovr_set_wins", ovr[0], 1);
    wait_idle();
    cycle(0, 8'h00, 4'h0, 1);
    check("ovr_clear2", ovr[0], 0);
    wait_idle();

    // Four clocks per bit, all-ones payload.
    f4 = 15'b011111111111101;
    e4 = '0;
    for (int j = 14; j >= 0; j--) repeat (4) e4 = {e4[58:0], f4[j]};
    pulse(8'hFF, 4'hF);
    s4 = {59'b0, tx[1]}; bc4 = busy[1]; par4 = 1'bx;
    for (int j = 1; j < 60; j++) begin
      idle(1);
      s4 = {s4[58:0], tx[1]};
      bc4 += busy[1];
      if (j == 53) par4 = tx[1];
    end
    check("cpb4_seq", s4, e4);
    check("cpb4_busy_cycles", bc4, 60);
    check("cpb4_parity", par4, 0);
    idle(1);
    check("cpb4_busy_after", busy[1], 0);
    wait_idle();

    // Asynchronous reset in the middle of a frame (bit 6 on the 1-clock instance).
    pulse(8'hA5, 4'h9);
    idle(6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_tx", tx, 2'b11);
    check("midrst_busy", busy, 2'b00);
    check("midrst_cnt", {cnt1, cnt0}, 16'h0000);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("postrst_tx", tx, 2'b11);

    // Randomized traffic.
    repeat (3000)
      cycle($urandom_range(0, 9) == 0, 8'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
